pc_ctrl: RTL
============

// Module: pc_ctrl
// PURPOSE
//  Owns the program counter and sequences the next-PC choice each cycle.
//  Drives the select of the PC branch mux, and arbitrates between stall, branch, interrupt entry and mret return.
//  Runs a small FSM for interrupt entry: a vector-table read, then a jump, with squash of the in-flight instruction.
//  Sits between decoder/ALU (branch resolution), the interrupt controller, and instruction fetch.
// PARAMETERS
//  AddrWidth    32           PC / address width, bits
//  IdWidth      4            interrupt id width; vector table holds 2**IdWidth entries
//  ResetVector  32'h0000_0000  PC value after reset
//  VecBase      32'h0000_1000  byte address of vector table entry 0, word aligned
// PORTS
//  clk          in   1          core clock
//  reset        in   1          synchronous, active-high reset
//  stall        in   1          freeze PC and FSM (RUN state only)
//  branch_taken in   1          resolved branch/jump this cycle
//  pc_branch    in   AddrWidth  branch/jump target
//  mret         in   1          current instruction is mret
//  irq_pend     in   1          interrupt controller has a pending request
//  irq_id       in   IdWidth    id of the pending request, sampled with irq_pend
//  vec_rdata    in   AddrWidth  vector-table read data, valid 1 cycle after vec_req
//  pc           out  AddrWidth  current PC (registered)
//  pc_sel       out  pc_branch_mux_t  select for PC branch mux (PC_NEXT / PC_BRANCH)
//  vec_req      out  1          vector-table read strobe
//  vec_addr     out  AddrWidth  VecBase + irq_id*4
//  squash       out  1          invalidate the instruction at pc this cycle
//  irq_ack      out  1          one-cycle pulse when vector jump commits
//  in_isr       out  1          handler active; irq entry blocked
// BEHAVIOUR
//  Reset: pc=ResetVector, state=RUN, ret_addr=0, in_isr=0.
//  Reset outputs: vec_req=0, squash=0, irq_ack=0, pc_sel=PC_NEXT.
//  pc_next = pc + 4, modulo 2**AddrWidth (wraps silently). pc_sel=PC_BRANCH iff branch_taken in RUN, else PC_NEXT.
//  RUN, priority high->low:
//   1. stall: pc, state, ret_addr and in_isr hold; no other action this cycle.
//   2. irq take (irq_pend && !in_isr):
//      - ret_addr <= (branch_taken ? pc_branch : pc_next); current instruction retires normally.
//      - latch irq_id; state <= VEC_RD; pc holds.
//   3. mret && in_isr: pc <= ret_addr, in_isr <= 0.
//   4. else pc <= mux output (pc_branch if branch_taken, else pc_next).
//      mret with !in_isr behaves as nop (pc_next).
//   mret and irq_pend in the same cycle: irq is blocked because in_isr=1, so mret completes; the pending irq is taken next RUN cycle.
//  VEC_RD (1 cycle):
//   - vec_req=1, vec_addr from latched id; squash=1.
//   - stall, branch_taken and mret ignored; -> VEC_JMP.
//  VEC_JMP (1 cycle):
//   - pc <= vec_rdata & ~3 (force word alignment); in_isr <= 1; irq_ack=1; squash=1; -> RUN.
//  Interrupt entry latency: take cycle + 2 cycles; the first handler instruction is at pc in cycle take+3.
//  reset asserted in any state aborts the sequence: no irq_ack, in_isr cleared.
//  Outputs vec_req, squash and irq_ack are decoded from state (Moore); pc_sel is combinational (Mealy).
// STRUCTURE
//  pc_ctrl_pkg:
//   - typedef enum logic [1:0] {PC_RUN, PC_VEC_RD, PC_VEC_JMP} pc_ctrl_state_t
//   - localparam VecStride = 4
//  pc_branch_mux_t is reused from decoder_pkg.
//  Sub-module: instantiate pc_branch_mux for the PC_NEXT/PC_BRANCH selection.
//  The FSM, PC register and ret_addr register stay in pc_ctrl.
// TESTING
//  - Reset then 3 free cycles -> pc = 0x0, 0x4, 0x8; pc_sel = PC_NEXT.
//  - pc=0x8, branch_taken=1, pc_branch=0x40 -> next pc=0x40; pc_sel=PC_BRANCH during the branch cycle.
//  - pc=0x10, stall=1 for 3 cycles with branch_taken=1 -> pc stays 0x10 and branch is ignored; after release, branch to 0x40.
//  - Interrupt entry: pc=0x20, irq_pend=1, irq_id=3:
//     - take cycle -> vec_addr=0x100C in next cycle.
//     - with vec_rdata=0x200 -> pc=0x200 at take+3; irq_ack pulses once; in_isr=1; ret_addr=0x24.
//  - In ISR, irq_pend=1 and mret=1 together -> pc=0x24, in_isr=0; irq taken the following cycle.
//  - reset asserted during VEC_RD -> pc=ResetVector next cycle; irq_ack never pulses; in_isr=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Decoder package (shared slice): types the decoder and PC controller agree on.
//   pc_branch_mux_t : select encoding for the PC branch mux
//                     (PC_NEXT = sequential pc+4, PC_BRANCH = resolved target).
package decoder_pkg;

  typedef enum logic {
    PC_NEXT   = 1'b0,
    PC_BRANCH = 1'b1
  } pc_branch_mux_t;

endpackage

// File: rtl/pc_ctrl_pkg.sv
// PC controller package: FSM state encoding and vector-table stride.
//   pc_ctrl_state_t : RUN / vector-table read / vector jump
//   VecStride       : byte distance between vector-table entries
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_VEC_RD  = 2'd1,
    PC_VEC_JMP = 2'd2
  } pc_ctrl_state_t;

  localparam int VecStride = 4;

endpackage

// File: rtl/pc_branch_mux.sv
// PC branch mux: chooses between the sequential PC and the branch target.
// Ports:
//   sel       in   pc_branch_mux_t  PC_NEXT / PC_BRANCH
//   pc_next   in   AddrWidth        sequential next PC
//   pc_branch in   AddrWidth        resolved branch/jump target
//   pc_out    out  AddrWidth        selected next PC
module pc_branch_mux
  import decoder_pkg::*;
#(
  parameter int AddrWidth = 32
) (
  input  pc_branch_mux_t       sel,
  input  logic [AddrWidth-1:0] pc_next,
  input  logic [AddrWidth-1:0] pc_branch,
  output logic [AddrWidth-1:0] pc_out
);

  assign pc_out = (sel == PC_BRANCH) ? pc_branch : pc_next;

endmodule

// File: rtl/pc_ctrl.sv
// PC controller: owns the program counter, picks the next PC each cycle and
// sequences interrupt entry (vector-table read, then jump) and mret return.
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   stall                 freeze PC/FSM while in RUN
//   branch_taken,pc_branch resolved branch and its target
//   mret                  current instruction is mret
//   irq_pend, irq_id      pending interrupt request and its id
//   vec_rdata             vector-table data, valid the cycle after vec_req
//   pc                    current PC (registered)
//   pc_sel                branch mux select (combinational)
//   vec_req, vec_addr     vector-table read strobe and address
//   squash                invalidate the instruction at pc this cycle
//   irq_ack               one-cycle pulse when the vector jump commits
//   in_isr                handler active, further irq entry blocked
module pc_ctrl
  import decoder_pkg::*;
  import pc_ctrl_pkg::*;
#(
  parameter int                 AddrWidth   = 32,
  parameter int                 IdWidth     = 4,
  parameter logic [AddrWidth-1:0] ResetVector = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] VecBase     = 32'h0000_1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [AddrWidth-1:0] pc_branch,
  input  logic                 mret,
  input  logic                 irq_pend,
  input  logic [IdWidth-1:0]   irq_id,
  input  logic [AddrWidth-1:0] vec_rdata,
  output logic [AddrWidth-1:0] pc,
  output pc_branch_mux_t       pc_sel,
  output logic                 vec_req,
  output logic [AddrWidth-1:0] vec_addr,
  output logic                 squash,
  output logic                 irq_ack,
  output logic                 in_isr
);

  localparam logic [AddrWidth-1:0] PcInc = AddrWidth'(4);

  pc_ctrl_state_t       state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] ret_addr_q, ret_addr_d;
  logic [IdWidth-1:0]   irq_id_q, irq_id_d;
  logic                 in_isr_q, in_isr_d;
  logic                 vec_req_q, squash_q, irq_ack_q;
  logic [AddrWidth-1:0] pc_next;
  logic [AddrWidth-1:0] mux_out;

  assign pc_next = pc_q + PcInc;  // wraps silently
  assign pc_sel  = (state_q == PC_RUN && branch_taken) ? PC_BRANCH : PC_NEXT;

  pc_branch_mux #(
    .AddrWidth(AddrWidth)
  ) u_pc_branch_mux (
    .sel      (pc_sel),
    .pc_next  (pc_next),
    .pc_branch(pc_branch),
    .pc_out   (mux_out)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ret_addr_d = ret_addr_q;
    irq_id_d   = irq_id_q;
    in_isr_d   = in_isr_q;
    case (state_q)
      PC_RUN: begin
        if (stall) begin
          // everything holds
        end else if (irq_pend && !in_isr_q) begin
          // current instruction retires, so the return point is its successor
          ret_addr_d = mux_out;
          irq_id_d   = irq_id;
          state_d    = PC_VEC_RD;
        end else if (mret && in_isr_q) begin
          pc_d     = ret_addr_q;
          in_isr_d = 1'b0;
        end else begin
          pc_d = mux_out;
        end
      end
      PC_VEC_RD: begin
        state_d = PC_VEC_JMP;
      end
      PC_VEC_JMP: begin
        pc_d     = {vec_rdata[AddrWidth-1:2], 2'b00};
        in_isr_d = 1'b1;
        state_d  = PC_RUN;
      end
      default: begin
        state_d = PC_RUN;
      end
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PC_RUN;
      pc_q       <= ResetVector;
      ret_addr_q <= '0;
      irq_id_q   <= '0;
      in_isr_q   <= 1'b0;
      vec_req_q  <= 1'b0;
      squash_q   <= 1'b0;
      irq_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_addr_q <= ret_addr_d;
      irq_id_q   <= irq_id_d;
      in_isr_q   <= in_isr_d;
      vec_req_q  <= (state_d == PC_VEC_RD);
      squash_q   <= (state_d == PC_VEC_RD) || (state_d == PC_VEC_JMP);
      irq_ack_q  <= (state_d == PC_VEC_JMP);
    end
  end

  assign pc       = pc_q;
  assign in_isr   = in_isr_q;
  assign vec_req  = vec_req_q;
  assign squash   = squash_q;
  assign irq_ack  = irq_ack_q;
  assign vec_addr = VecBase + AddrWidth'(irq_id_q) * AddrWidth'(VecStride);

endmodule
